rr_mux4_arbiter: RTL



---
 rtl/rr_mux4_pkg.sv | 17 +
 rtl/rr_pick4.sv | 47 ++++
 rtl/rr_mux4_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/rr_mux4_pkg.sv
// Shared types and helpers for the four-source round-robin mux arbiter.
package rr_mux4_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Search starts just past the most recent winner; 3 wraps to 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request at or after ptr, modulo 4.
module rr_pick4
    import rr_mux4_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [SEL_W-1:0] p1_s;
    logic [SEL_W-1:0] p2_s;
    logic [SEL_W-1:0] p3_s;
    logic [N_REQ-1:0] rot_s;
    logic [SEL_W-1:0] off_s;

    assign p1_s = ptr + 2'd1;
    assign p2_s = ptr + 2'd2;
    assign p3_s = ptr + 2'd3;

    // Rotate requests so bit 0 is the highest-priority source.
    assign rot_s = {req[p3_s], req[p2_s], req[p1_s], req[ptr]};

    // Priority encode the rotated vector, then map the offset back to a source index.
    always_comb begin
        found = 1'b1;
        off_s = 2'd0;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                found = 1'b0;
                off_s = 2'd0;
            end
        endcase
        idx = ptr + off_s;
        if (found) begin
            onehot = 4'b0001 << idx;
        end else begin
            onehot = 4'b0000;
        end
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter feeding a 4:1 mux into a one-entry valid/ready output register.
module rr_mux4_arbiter
    import rr_mux4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             s1,
    output logic             s0
);

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;
    logic [SEL_W-1:0] sel_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] data_d;
    logic             found_s;
    logic [SEL_W-1:0] idx_s;
    logic [N_REQ-1:0] onehot_s;
    logic             load_s;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .found  (found_s),
        .idx    (idx_s),
        .onehot (onehot_s)
    );

    // A slot is free when empty or when the held word leaves this cycle.
    assign load_s = ((state_q == EMPTY) || y_ready) && found_s;
    assign ptr_d  = next_ptr(idx_s);

    // rst_n gates the pulse so nothing is accepted while reset is held.
    assign gnt = (rst_n && load_s) ? onehot_s : 4'b0000;

    // 4:1 datapath mux steered by the winning index.
    always_comb begin
        case (idx_s)
            2'd0:    data_d = a;
            2'd1:    data_d = b;
            2'd2:    data_d = c;
            2'd3:    data_d = d;
            default: data_d = a;
        endcase
    end

    // Output-stage FSM: refill on load, drain on accept, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            y_q     <= '0;
        end else if (load_s) begin
            state_q <= FULL;
            ptr_q   <= ptr_d;
            sel_q   <= idx_s;
            y_q     <= data_d;
        end else if ((state_q == FULL) && y_ready) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_q;
        end
    end

    assign y       = y_q;
    assign y_valid = (state_q == FULL);
    assign s1      = sel_q[1];
    assign s0      = sel_q[0];

endmodule
